tristate_bus_arbiter: RTL and testbench



---
 rtl/tristate_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter that puts one of N channels on a shared WIDTH-bit tristate bus,
// with a registered enable, a programmable high-Z gap between owners and optional preemption.
//
// state | meaning
// IDLE  | bus not owned; arbitrate among requests when E is high
// DRIVE | owner in grant drives Y from data_q, re-captured every edge
// GAP   | high-Z turnaround after a release; counts gap_cnt down to IDLE
module tristate_bus_arbiter #(
  parameter int WIDTH    = 4,
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               E,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] A,
  output logic [N-1:0]       grant,
  output logic               busy,
  output wire  [WIDTH-1:0]   Y
);

  localparam int MX = (MAX_HOLD > TURN) ? MAX_HOLD : TURN;
  localparam int CW = (MX < 1) ? 1 : $clog2(MX + 1);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state;
  logic            oe;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   gap_cnt;
  logic [LW-1:0]   last;
  logic [LW-1:0]   winner;
  logic [N-1:0]    win_oh;
  logic            found;
  logic            others_req;
  logic            release_now;
  logic            preempt;

  // Cyclic search starting just after the last owner
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found  = 1'b1;
        winner = LW'((int'(last) + k) % N);
      end
    end
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  // In DRIVE the owner index is always last, and grant is its one-hot
  assign others_req  = |(req & ~grant);
  assign release_now = !req[last] || !E;
  assign preempt     = (MAX_HOLD > 0) && (hold_cnt == CW'(MAX_HOLD)) && others_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      oe       <= 1'b0;
      data_q   <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      last     <= LW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          grant <= '0;
          if (E && found) begin
            state    <= DRIVE;
            grant    <= win_oh;
            last     <= winner;
            oe       <= 1'b1;
            busy     <= 1'b1;
            data_q   <= A[int'(winner)*WIDTH +: WIDTH];
            hold_cnt <= CW'(1);
          end
        end
        DRIVE: begin
          if (release_now || preempt) begin
            grant    <= '0;
            oe       <= 1'b0;
            hold_cnt <= '0;
            if (TURN > 0) begin
              state   <= GAP;
              gap_cnt <= CW'(TURN);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            data_q <= A[int'(last)*WIDTH +: WIDTH];
            if (MAX_HOLD > 0 && hold_cnt != CW'(MAX_HOLD))
              hold_cnt <= hold_cnt + CW'(1);
          end
        end
        GAP: begin
          grant <= '0;
          if (gap_cnt == CW'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          oe    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Y = (oe && E) ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: one instance with TURN=1/MAX_HOLD=4 and one
// with TURN=3/MAX_HOLD=0. Bus nets are pulled up, so a floating Y reads as 4'hF.
module tb_tristate_bus_arbiter;

  localparam logic [7:0] FLOAT = 8'h0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        E = 1'b0;
  logic [3:0]  req0 = '0;
  logic [3:0]  req1 = '0;
  logic [15:0] a0 = '0;
  logic [15:0] a1 = '0;
  logic [3:0]  grant0, grant1;
  logic        busy0, busy1;
  wire  [3:0]  y0, y1;

  int n_cmp = 0;
  int n_err = 0;

  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (y0[i]);
    pullup (y1[i]);
  end

  tristate_bus_arbiter #(.WIDTH(4), .N(4), .TURN(1), .MAX_HOLD(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .E(E), .req(req0), .A(a0),
    .grant(grant0), .busy(busy0), .Y(y0)
  );

  tristate_bus_arbiter #(.WIDTH(4), .N(4), .TURN(3), .MAX_HOLD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .E(E), .req(req1), .A(a1),
    .grant(grant1), .busy(busy1), .Y(y1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    E = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("rst_grant", 8'(grant0), 8'h00);
      check_val("rst_busy", 8'(busy0), 8'h00);
      check_val("rst_y", 8'(y0), FLOAT);
    end

    // single owner on ch1, Y lags A by one cycle
    req0 = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      a0[7:4] = 4'(k);
      tick();
      check_val("single_grant", 8'(grant0), 8'h02);
      check_val("single_y", 8'(y0), 8'(k));
      check_val("single_busy", 8'(busy0), 8'h01);
    end
    req0 = 4'b0000;
    tick();
    check_val("rel_grant", 8'(grant0), 8'h00);
    check_val("rel_y", 8'(y0), FLOAT);
    check_val("rel_busy_gap", 8'(busy0), 8'h01);
    tick();
    check_val("rel_busy_idle", 8'(busy0), 8'h00);

    // round-robin with preemption after 4 cycles: 4 owned, 1 gap, 1 idle
    do_reset();
    a0   = {4'h4, 4'h3, 4'h2, 4'h1};
    req0 = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 6; k++) begin
        tick();
        if (k < 4) begin
          check_val("rr_grant", 8'(grant0), 8'(1 << (r % 4)));
          check_val("rr_y", 8'(y0), 8'((r % 4) + 1));
        end else begin
          check_val("rr_gap_grant", 8'(grant0), 8'h00);
          check_val("rr_gap_y", 8'(y0), FLOAT);
        end
      end
    end

    // enable gating
    do_reset();
    req0 = 4'b0001;
    tick();
    check_val("en_grant", 8'(grant0), 8'h01);
    tick();
    check_val("en_y_driven", 8'(y0), 8'h01);
    #3 E = 1'b0;
    #1;
    check_val("en_y_float_now", 8'(y0), FLOAT);
    check_val("en_grant_held", 8'(grant0), 8'h01);
    tick();
    check_val("en_grant_drop", 8'(grant0), 8'h00);
    check_val("en_busy_gap", 8'(busy0), 8'h01);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("en_no_grant", 8'(grant0), 8'h00);
      check_val("en_no_busy", 8'(busy0), 8'h00);
    end
    E = 1'b1;
    tick();
    check_val("en_resume_grant", 8'(grant0), 8'h01);
    check_val("en_resume_y", 8'(y0), 8'h01);
    req0 = 4'b0000;

    // turnaround on the TURN=3 instance: 3 gap cycles plus the arbitration cycle
    do_reset();
    a1   = {4'h7, 4'h6, 4'h5, 4'h3};
    req1 = 4'b0001;
    tick();
    check_val("ta_grant0", 8'(grant1), 8'h01);
    req1 = 4'b0101;
    tick();
    check_val("ta_no_preempt", 8'(grant1), 8'h01);
    check_val("ta_y0", 8'(y1), 8'h03);
    req1 = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("ta_gap_grant", 8'(grant1), 8'h00);
      check_val("ta_gap_y", 8'(y1), FLOAT);
      check_val("ta_gap_busy", 8'(busy1), (k < 3) ? 8'h01 : 8'h00);
    end
    tick();
    check_val("ta_grant2", 8'(grant1), 8'h04);
    check_val("ta_y2", 8'(y1), 8'h06);
    req1 = 4'b0000;

    // async reset in the middle of DRIVE
    do_reset();
    a0   = {4'h4, 4'h3, 4'h2, 4'h1};
    req0 = 4'b0100;
    tick();
    check_val("ar_grant", 8'(grant0), 8'h04);
    check_val("ar_y", 8'(y0), 8'h03);
    req0 = 4'b0101;
    #3 rst_n = 1'b0;
    #1;
    check_val("ar_grant_now", 8'(grant0), 8'h00);
    check_val("ar_y_now", 8'(y0), FLOAT);
    check_val("ar_busy_now", 8'(busy0), 8'h00);
    #2 rst_n = 1'b1;
    tick();
    check_val("ar_ch0_first", 8'(grant0), 8'h01);
    check_val("ar_ch0_y", 8'(y0), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
